kbd_event_fifo: RTL and testbench



---
 rtl/kbd_event_fifo.sv | 257 +++++++++++++++++++++++++
 tb/tb_kbd_event_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/kbd_event_fifo.sv
// -----------------------------------------------------------------------------
// kbd_event_fifo
// Folds raw PS/2 set-2 scancode bytes into key events and queues them in a
// first-word-fall-through FIFO for the CPU port decoder.
//
// Event entry: {ext, up, code[7:0]}
//   F0 prefix          -> up (release) flag
//   E0 prefix          -> ext flag
//   E1 + 7 bytes       -> single Pause event {1,0,E1}
//
// Parameters:
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 entries
//   TIMEOUT     idle clk cycles before a pending prefix is abandoned
//
// Ports:
//   clk          system clock, posedge
//   rst          synchronous active-high reset
//   ps2_data     received PS/2 byte
//   ps2_data_en  one-cycle strobe, ps2_data valid
//   rd           one-cycle pop strobe
//   clr_ovf      one-cycle strobe, clears ovf
//   dout         head-entry scancode (combinational from storage)
//   dout_up      head entry is a release
//   dout_ext     head entry had an E0/E1 prefix
//   empty, full  FIFO status
//   count        entries held
//   ovf          sticky: an event was dropped
//   intr         interrupt request
//
// Optional feature macro: KBD_EVENT_FIFO_INTR_EN
//   defined   -> intr is !empty delayed one cycle (registered)
//   undefined -> intr tied to 0
// -----------------------------------------------------------------------------
module kbd_event_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_data_en,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [7:0]            dout,
  output logic                  dout_up,
  output logic                  dout_ext,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  output logic                  intr
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_PAUSE = 8'hE1;
  localparam logic [7:0] B_FAKE  = 8'h12;

  typedef struct packed {
    logic       ext;
    logic       up;
    logic [7:0] code;
  } kbd_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } state_t;

  // Controller/keyboard status bytes that never form key events
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             push_c;
  kbd_evt_t         push_evt_c;

  // ---------------------------------------------------------------------------
  // Decoder FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Decoder FSM: next state
  always_comb begin
    state_d = state_q;
    if (ps2_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if      (ps2_data == B_BRK)   state_d = ST_BRK;
          else if (ps2_data == B_EXT)   state_d = ST_EXT;
          else if (ps2_data == B_PAUSE) state_d = ST_PAUSE;
        end
        ST_EXT:    state_d = (ps2_data == B_BRK) ? ST_EXTBRK : ST_IDLE;
        ST_BRK:    state_d = ST_IDLE;
        ST_EXTBRK: state_d = ST_IDLE;
        ST_PAUSE:  if (skip_q <= 3'd1) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_MAX) begin
      // Abandon a stale prefix without producing an event
      state_d = ST_IDLE;
    end
  end

  // Decoder FSM: outputs (event push)
  always_comb begin
    push_c     = 1'b0;
    push_evt_c = '0;
    if (ps2_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data != B_BRK && ps2_data != B_EXT &&
              ps2_data != B_PAUSE && !is_discard(ps2_data)) begin
            push_c     = 1'b1;
            push_evt_c = '{ext: 1'b0, up: 1'b0, code: ps2_data};
          end
        end
        ST_EXT: begin
          if (ps2_data != B_BRK && ps2_data != B_FAKE) begin
            push_c     = 1'b1;
            push_evt_c = '{ext: 1'b1, up: 1'b0, code: ps2_data};
          end
        end
        ST_BRK: begin
          push_c     = 1'b1;
          push_evt_c = '{ext: 1'b0, up: 1'b1, code: ps2_data};
        end
        ST_EXTBRK: begin
          if (ps2_data != B_FAKE) begin
            push_c     = 1'b1;
            push_evt_c = '{ext: 1'b1, up: 1'b1, code: ps2_data};
          end
        end
        ST_PAUSE: begin
          if (skip_q == 3'd1) begin
            push_c     = 1'b1;
            push_evt_c = '{ext: 1'b1, up: 1'b0, code: B_PAUSE};
          end
        end
        default: ;
      endcase
    end
  end

  // Pause skip counter and prefix timeout counter
  always_comb begin
    skip_d = skip_q;
    if (ps2_data_en) begin
      if (state_q == ST_IDLE && ps2_data == B_PAUSE) skip_d = 3'd7;
      else if (state_q == ST_PAUSE && skip_q != 3'd0) skip_d = skip_q - 3'd1;
    end
    tmo_d = (ps2_data_en || state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= 3'd0;
      tmo_q  <= '0;
    end else begin
      skip_q <= skip_d;
      tmo_q  <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  kbd_evt_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 empty_q, full_q, ovf_q, ovf_d;
  kbd_evt_t             last_q;
  kbd_evt_t             head_c;
  logic                 rd_ok_c, wr_en_c, drop_c;

  // A pop frees the slot in the same cycle, so push+pop while full is legal
  assign rd_ok_c = rd && !empty_q;
  assign drop_c  = push_c && full_q && !rd_ok_c;
  assign wr_en_c = push_c && !drop_c;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en_c, rd_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear
    ovf_d = drop_c ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == CNT_W'(0));
      full_q  <= (count_d == CNT_W'(DEPTH));
      ovf_q   <= ovf_d;
      // Remember the visible head so outputs hold once the FIFO drains
      if (!empty_q) last_q <= head_c;
    end
  end

  // Storage has no reset; only valid slots are ever shown
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) mem_q[wr_ptr_q] <= push_evt_c;
  end

  assign head_c   = mem_q[rd_ptr_q];
  assign dout     = empty_q ? last_q.code : head_c.code;
  assign dout_up  = empty_q ? last_q.up   : head_c.up;
  assign dout_ext = empty_q ? last_q.ext  : head_c.ext;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

  // ---------------------------------------------------------------------------
  // Interrupt request
  // ---------------------------------------------------------------------------
`ifdef KBD_EVENT_FIFO_INTR_EN
  logic intr_q;
  always_ff @(posedge clk) begin
    if (rst) intr_q <= 1'b0;
    else     intr_q <= !empty_q;
  end
  assign intr = intr_q;
`else
  assign intr = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Directed testbench for kbd_event_fifo (TIMEOUT reduced to 100 cycles).
module tb_kbd_event_fifo;

  localparam int unsigned DL2 = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ps2_data;
  logic         ps2_data_en;
  logic         rd;
  logic         clr_ovf;
  logic [7:0]   dout;
  logic         dout_up;
  logic         dout_ext;
  logic         empty;
  logic         full;
  logic [DL2:0] count;
  logic         ovf;
  logic         intr;

  int checks = 0;
  int errors = 0;

`ifdef KBD_EVENT_FIFO_INTR_EN
  localparam logic INTR_ON = 1'b1;
`else
  localparam logic INTR_ON = 1'b0;
`endif

  kbd_event_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .rd(rd), .clr_ovf(clr_ovf), .dout(dout), .dout_up(dout_up),
    .dout_ext(dout_ext), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .intr(intr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic send_byte(input logic [7:0] b, input logic with_rd = 1'b0);
    @(negedge clk);
    ps2_data = b; ps2_data_en = 1'b1; rd = with_rd;
    @(negedge clk);
    ps2_data_en = 1'b0; rd = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_data = 8'h00; ps2_data_en = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b want 0", intr); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h000) begin errors++; $display("FAIL reset_dout: got %h want 000", {dout_ext, dout_up, dout}); end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL mb_count: got %0d want 2", count); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h01C) begin errors++; $display("FAIL mb_head0: got %h want 01c", {dout_ext, dout_up, dout}); end
    pop();
    checks++; if ({dout_ext, dout_up, dout} !== 10'h11C) begin errors++; $display("FAIL mb_head1: got %h want 11c", {dout_ext, dout_up, dout}); end
    pop();
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL mb_empty: got empty=%b count=%0d want 1/0", empty, count); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h11C) begin errors++; $display("FAIL mb_hold: got %h want 11c", {dout_ext, dout_up, dout}); end
    // Pop on empty is ignored
    pop();
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL mb_rd_empty: got count=%0d want 0", count); end
  endtask

  task automatic test_ext();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL ext_count: got %0d want 1", count); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h375) begin errors++; $display("FAIL ext_brk: got %h want 375", {dout_ext, dout_up, dout}); end
    pop();
    send_byte(8'hE0); send_byte(8'h75);
    checks++; if ({count, dout_ext, dout_up, dout} !== {5'd1, 10'h275}) begin errors++; $display("FAIL ext_make: got %0d/%h want 1/275", count, {dout_ext, dout_up, dout}); end
    pop();
    send_byte(8'hE0); send_byte(8'h12);
    repeat (2) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ext_fake_shift: got %0d want 0", count); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL extbrk_fake_shift: got %0d want 0", count); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) send_byte(seq[i]);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL pause_early: got %0d want 0", count); end
    send_byte(seq[7]);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL pause_count: got %0d want 1", count); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h2E1) begin errors++; $display("FAIL pause_evt: got %h want 2e1", {dout_ext, dout_up, dout}); end
    pop();
    send_byte(8'hAA); send_byte(8'hFA);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL discard: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) send_byte(8'(i));
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_full: got full=%b count=%0d want 1/16", full, count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    checks++; if ({dout_ext, dout_up, dout} !== 10'h001) begin errors++; $display("FAIL ovf_head: got %h want 001", {dout_ext, dout_up, dout}); end
    send_byte(8'h20, 1'b1);
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_pushpop: got count=%0d want 16", count); end
    checks++; if (dout !== 8'h02) begin errors++; $display("FAIL ovf_newhead: got %h want 02", dout); end
    for (int i = 0; i < 15; i++) pop();
    checks++; if (dout !== 8'h20 || count !== 5'd1) begin errors++; $display("FAIL ovf_wrap: got %h/%0d want 20/1", dout, count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    pop();
  endtask

  task automatic test_timeout();
    send_byte(8'hF0);
    repeat (40) @(negedge clk);
    send_byte(8'h1C);
    checks++; if ({count, dout_ext, dout_up, dout} !== {5'd1, 10'h11C}) begin errors++; $display("FAIL tmo_short: got %0d/%h want 1/11c", count, {dout_ext, dout_up, dout}); end
    pop();
    send_byte(8'hF0);
    repeat (100) @(negedge clk);
    send_byte(8'h1C);
    checks++; if ({count, dout_ext, dout_up, dout} !== {5'd1, 10'h01C}) begin errors++; $display("FAIL tmo_expire: got %0d/%h want 1/01c", count, {dout_ext, dout_up, dout}); end
    pop();
  endtask

  task automatic test_rst_mid();
    send_byte(8'h33); send_byte(8'h34); send_byte(8'hF0);
    do_reset();
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL rst_mid_fifo: got empty=%b count=%0d want 1/0", empty, count); end
    send_byte(8'h1C);
    checks++; if ({dout_ext, dout_up, dout} !== 10'h01C) begin errors++; $display("FAIL rst_mid_state: got %h want 01c", {dout_ext, dout_up, dout}); end
    pop();
  endtask

  task automatic test_intr();
    send_byte(8'h45);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_lag: got %b want 0", intr); end
    @(negedge clk);
    checks++; if (intr !== INTR_ON) begin errors++; $display("FAIL intr_rise: got %b want %b", intr, INTR_ON); end
    pop();
    checks++; if (empty !== 1'b1 || intr !== INTR_ON) begin errors++; $display("FAIL intr_hold: got empty=%b intr=%b want 1/%b", empty, intr, INTR_ON); end
    @(negedge clk);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_fall: got %b want 0", intr); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_ext();
    test_pause();
    test_overflow();
    test_timeout();
    test_rst_mid();
    test_intr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
